// File: rtl/spi_cmd_sequencer_if.sv
// Byte-level link between the SPI slave, the command sequencer and the image pipeline.
// The slave modport is the sequencer side; master is the driver/observer side.
interface spi_cmd_sequencer_if #(
    parameter int unsigned REG_N     = 8,
    parameter int unsigned PIX_BYTES = 6
);
    logic                   css;
    logic                   byte_rdy;
    logic [7:0]             byte_i;
    logic [7:0]             stream_dat_i;
    logic [7:0]             feed_o;
    logic [REG_N*8-1:0]     reg_o;
    logic [PIX_BYTES*8-1:0] pix_o;
    logic                   pix_vld_o;
    logic                   stream_on_o;
    logic                   screen_rst_o;
    logic [7:0]             err_cnt_o;

    modport slave (
        input  css, byte_rdy, byte_i, stream_dat_i,
        output feed_o, reg_o, pix_o, pix_vld_o, stream_on_o, screen_rst_o, err_cnt_o
    );

    modport master (
        output css, byte_rdy, byte_i, stream_dat_i,
        input  feed_o, reg_o, pix_o, pix_vld_o, stream_on_o, screen_rst_o, err_cnt_o
    );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// SPI command decoder: register bank write/read-back, screen-reset control and pixel streaming
// into PIX_BYTES-wide words. Every output is registered on clk_p.
module spi_cmd_sequencer #(
    parameter int unsigned REG_N     = 8,
    parameter int unsigned PIX_BYTES = 6
) (
    input  logic                clk_p,
    input  logic                rst_p,
    spi_cmd_sequencer_if.slave  bus
);
    localparam int unsigned AW   = (REG_N > 1) ? $clog2(REG_N) : 1;
    localparam int unsigned CW   = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam int unsigned PW   = PIX_BYTES * 8;
    localparam logic [CW-1:0] CntLast = CW'(PIX_BYTES - 1);
    localparam logic [8:0]    RegLim  = 9'(REG_N);

    localparam logic [7:0] CmdRead   = 8'h81;
    localparam logic [7:0] CmdWrite  = 8'h80;
    localparam logic [7:0] CmdStream = 8'h55;
    localparam logic [7:0] CmdScrLo  = 8'h40;
    localparam logic [7:0] CmdScrHi  = 8'h41;

    typedef enum logic [2:0] {
        StCmd,
        StRdAddr,
        StWrAddr,
        StWrData,
        StStream
    } state_e;

    state_e             state_q;
    logic [7:0]         feed_q;
    logic [REG_N*8-1:0] regs_q;
    logic [PW-1:0]      shift_q;
    logic [PW-1:0]      pix_q;
    logic               pix_vld_q;
    logic               stream_on_q;
    logic               screen_rst_q;
    logic [7:0]         err_cnt_q;
    logic [7:0]         wr_addr_q;
    logic [CW-1:0]      cnt_q;

    logic          byte_in_range;
    logic          wr_in_range;
    logic [PW-1:0] shift_next;

    // Address bytes are full 8-bit values; anything at or above REG_N is out of range.
    assign byte_in_range = {1'b0, bus.byte_i} < RegLim;
    assign wr_in_range   = {1'b0, wr_addr_q} < RegLim;

    if (PIX_BYTES > 1) begin : g_shift_wide
        assign shift_next = {shift_q[PW-9:0], bus.byte_i};
    end else begin : g_shift_narrow
        assign shift_next = bus.byte_i;
    end

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            state_q      <= StCmd;
            feed_q       <= 8'hFF;
            regs_q       <= '0;
            shift_q      <= '0;
            pix_q        <= '0;
            pix_vld_q    <= 1'b0;
            stream_on_q  <= 1'b0;
            screen_rst_q <= 1'b0;
            err_cnt_q    <= 8'h00;
            wr_addr_q    <= 8'h00;
            cnt_q        <= '0;
        end else begin
            pix_vld_q <= 1'b0;
            // Deselect wins over a coincident byte; the byte is dropped untouched.
            if (!bus.css) begin
                state_q     <= StCmd;
                feed_q      <= 8'hFF;
                shift_q     <= '0;
                stream_on_q <= 1'b0;
                cnt_q       <= '0;
            end else if (bus.byte_rdy) begin
                unique case (state_q)
                    StCmd: begin
                        feed_q <= 8'hFF;
                        case (bus.byte_i)
                            CmdRead:  state_q <= StRdAddr;
                            CmdWrite: state_q <= StWrAddr;
                            CmdStream: begin
                                state_q     <= StStream;
                                stream_on_q <= 1'b1;
                                cnt_q       <= '0;
                                shift_q     <= '0;
                            end
                            CmdScrLo: screen_rst_q <= 1'b0;
                            CmdScrHi: screen_rst_q <= 1'b1;
                            default: begin
                                if (err_cnt_q != 8'hFF) begin
                                    err_cnt_q <= err_cnt_q + 8'h01;
                                end
                            end
                        endcase
                    end
                    StRdAddr: begin
                        feed_q  <= byte_in_range ?
                                   regs_q[{bus.byte_i[AW-1:0], 3'b000} +: 8] : 8'h00;
                        state_q <= StCmd;
                    end
                    StWrAddr: begin
                        feed_q    <= 8'hFF;
                        wr_addr_q <= bus.byte_i;
                        state_q   <= StWrData;
                    end
                    StWrData: begin
                        feed_q <= 8'hFF;
                        if (wr_in_range) begin
                            regs_q[{wr_addr_q[AW-1:0], 3'b000} +: 8] <= bus.byte_i;
                        end
                        state_q <= StCmd;
                    end
                    StStream: begin
                        feed_q  <= bus.stream_dat_i;
                        shift_q <= shift_next;
                        if (cnt_q == CntLast) begin
                            pix_q     <= shift_next;
                            pix_vld_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q     <= StCmd;
                        feed_q      <= 8'hFF;
                        stream_on_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.feed_o       = feed_q;
    assign bus.reg_o        = regs_q;
    assign bus.pix_o        = pix_q;
    assign bus.pix_vld_o    = pix_vld_q;
    assign bus.stream_on_o  = stream_on_q;
    assign bus.screen_rst_o = screen_rst_q;
    assign bus.err_cnt_o    = err_cnt_q;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: feed_o and pixel words are queued at stimulus time
// and popped by a negedge monitor; level outputs are checked directly.
module tb_spi_cmd_sequencer;
    logic clk_p = 1'b0;
    logic rst_p = 1'b1;

    spi_cmd_sequencer_if #(.REG_N(8), .PIX_BYTES(6)) bus ();

    spi_cmd_sequencer #(.REG_N(8), .PIX_BYTES(6)) dut (
        .clk_p (clk_p),
        .rst_p (rst_p),
        .bus   (bus)
    );

    always #5 clk_p = ~clk_p;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  feed_exp[$];
    logic [47:0] pix_exp[$];
    logic        acc_q;
    logic        vld_prev = 1'b0;
    int          exp_err  = 0;
    logic [63:0] exp_regs = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // A byte is accepted on an edge where byte_rdy and css are both high.
    always @(posedge clk_p or posedge rst_p) begin
        if (rst_p) acc_q <= 1'b0;
        else       acc_q <= bus.byte_rdy && bus.css;
    end

    always @(negedge clk_p) begin
        if (acc_q) begin
            if (feed_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL feed_unexpected: got 0x%0h, expected no byte", bus.feed_o);
            end else begin
                check("feed", {56'b0, bus.feed_o}, {56'b0, feed_exp.pop_front()});
            end
        end
        if (bus.pix_vld_o) begin
            check("pix_vld_gap", {63'b0, vld_prev}, 64'd0);
            if (pix_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pix_unexpected: got 0x%0h, expected no pixel", bus.pix_o);
            end else begin
                check("pix", {16'b0, bus.pix_o}, {16'b0, pix_exp.pop_front()});
            end
        end
        vld_prev = bus.pix_vld_o;
    end

    task automatic send(input logic [7:0] b, input logic [7:0] exp_feed);
        feed_exp.push_back(exp_feed);
        bus.byte_i   = b;
        bus.byte_rdy = 1'b1;
        @(posedge clk_p);
        #1;
        bus.byte_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_p);
            #1;
        end
    endtask

    task automatic deselect();
        bus.css = 1'b0;
        @(posedge clk_p);
        #1;
        check("deselect_feed", {56'b0, bus.feed_o}, 64'hFF);
        check("deselect_stream_on", {63'b0, bus.stream_on_o}, 64'd0);
        bus.css = 1'b1;
    endtask

    task automatic check_levels(input string tag);
        check({tag, "_err"}, {56'b0, bus.err_cnt_o}, 64'(exp_err));
        check({tag, "_regs"}, bus.reg_o, exp_regs);
    endtask

    initial begin
        logic [7:0] pix_a [6];
        bus.css          = 1'b0;
        bus.byte_rdy     = 1'b0;
        bus.byte_i       = 8'h00;
        bus.stream_dat_i = 8'h3C;
        pix_a = '{8'h55, 8'h80, 8'h41, 8'h40, 8'h81, 8'h13};
        idle(2);
        rst_p = 1'b0;
        idle(1);

        check("rst_feed", {56'b0, bus.feed_o}, 64'hFF);
        check("rst_pix", {16'b0, bus.pix_o}, 64'd0);
        check("rst_vld", {63'b0, bus.pix_vld_o}, 64'd0);
        check("rst_stream_on", {63'b0, bus.stream_on_o}, 64'd0);
        check("rst_screen", {63'b0, bus.screen_rst_o}, 64'd0);
        check_levels("rst");
        bus.css = 1'b1;

        // Register write then read-back
        send(8'h80, 8'hFF);
        send(8'h02, 8'hFF);
        send(8'hA5, 8'hFF);
        exp_regs[23:16] = 8'hA5;
        check("wr_reg2", {56'b0, bus.reg_o[23:16]}, 64'hA5);
        deselect();
        send(8'h81, 8'hFF);
        send(8'h02, 8'hA5);
        check("rd_reg2", {56'b0, bus.feed_o}, 64'hA5);
        send(8'h00, 8'hFF);
        exp_err++;
        send(8'h81, 8'hFF);
        send(8'h09, 8'h00);
        check("rd_oor", {56'b0, bus.feed_o}, 64'h00);
        // Out-of-range write is discarded silently; in-range write to reg 7
        send(8'h80, 8'hFF);
        send(8'h0A, 8'hFF);
        send(8'h77, 8'hFF);
        send(8'h80, 8'hFF);
        send(8'h07, 8'hFF);
        send(8'h3E, 8'hFF);
        exp_regs[63:56] = 8'h3E;
        check_levels("wr_oor");

        // Streaming, back-to-back bytes
        send(8'h55, 8'hFF);
        check("stream_on_rise", {63'b0, bus.stream_on_o}, 64'd1);
        pix_exp.push_back(48'h010203040506);
        pix_exp.push_back(48'h0708090A0B0C);
        for (int i = 1; i <= 12; i++) send(8'(i), 8'h3C);
        idle(2);
        check("stream_done", 64'(pix_exp.size()), 64'd0);
        check("stream_on_hold", {63'b0, bus.stream_on_o}, 64'd1);
        deselect();

        // Deselect coincident with a byte mid-pixel
        bus.stream_dat_i = 8'hC3;
        send(8'h55, 8'hFF);
        for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), 8'hC3);
        bus.css      = 1'b0;
        bus.byte_i   = 8'h99;
        bus.byte_rdy = 1'b1;
        @(posedge clk_p);
        #1;
        bus.byte_rdy = 1'b0;
        bus.css      = 1'b1;
        check("dsel_stream_on", {63'b0, bus.stream_on_o}, 64'd0);
        check("dsel_feed", {56'b0, bus.feed_o}, 64'hFF);
        check("dsel_no_pix", {63'b0, bus.pix_vld_o}, 64'd0);
        send(8'h55, 8'hFF);
        pix_exp.push_back(48'h558041408113);
        for (int i = 0; i < 6; i++) send(pix_a[i], 8'hC3);
        idle(2);
        check("dsel_pix_done", 64'(pix_exp.size()), 64'd0);
        check_levels("dsel");
        deselect();

        // Screen control and error saturation
        send(8'h41, 8'hFF);
        check("screen_hi", {63'b0, bus.screen_rst_o}, 64'd1);
        send(8'h40, 8'hFF);
        check("screen_lo", {63'b0, bus.screen_rst_o}, 64'd0);
        for (int i = 0; i < 300; i++) begin
            send(8'h13, 8'hFF);
            if (exp_err < 255) exp_err++;
        end
        check("err_sat", {56'b0, bus.err_cnt_o}, 64'd255);
        check_levels("err");

        // Reset mid-stream after 3 pixel bytes
        send(8'h41, 8'hFF);
        send(8'h55, 8'hFF);
        for (int i = 0; i < 3; i++) send(8'hB0 + 8'(i), 8'hC3);
        idle(1);
        rst_p = 1'b1;
        #1;
        exp_err  = 0;
        exp_regs = '0;
        check("mrst_feed", {56'b0, bus.feed_o}, 64'hFF);
        check("mrst_pix", {16'b0, bus.pix_o}, 64'd0);
        check("mrst_stream_on", {63'b0, bus.stream_on_o}, 64'd0);
        check("mrst_screen", {63'b0, bus.screen_rst_o}, 64'd0);
        check_levels("mrst");
        @(posedge clk_p);
        #1;
        rst_p = 1'b0;
        send(8'h55, 8'hFF);
        pix_exp.push_back(48'h0A0B0C0D0E0F);
        for (int i = 0; i < 6; i++) send(8'h0A + 8'(i), 8'hC3);
        idle(3);
        check("post_rst_pix_done", 64'(pix_exp.size()), 64'd0);
        check("feed_queue_empty", 64'(feed_exp.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Byte-level command sequencer between the SPI slave and the image pipeline. It decodes the SPI command protocol: register write, register read-back, screen-reset control and pixel streaming. It holds the 8-entry configuration register bank and packs streamed bytes into 6-byte pixel pairs with a one-cycle valid strobe. It also selects the byte returned to the host on each transfer. It sits in the `clk_p` domain, downstream of `SPI_slave` and upstream of the pixel source mux and `PixCoordinator`.

## Interface
Parameters:
- `REG_N`, default 8: number of 8-bit configuration registers; address width is `$clog2(REG_N)`.
- `PIX_BYTES`, default 6: bytes per streamed pixel word.

Ports:
- `clk_p`, in, 1: system clock. One clock; every output is registered on its rising edge.
- `rst_p`, in, 1: reset, asynchronous and active-high. Clears all state.
- `css`, in, 1: chip select, already synchronous to `clk_p`. 0 means deselected, 1 means transfer active.
- `byte_rdy`, in, 1: one-cycle strobe marking a complete received byte.
- `byte_i`, in, 8: received byte, valid when `byte_rdy`=1.
- `stream_dat_i`, in, 8: pipeline result byte returned to the host while streaming.
- `feed_o`, out, 8: byte the SPI slave shifts out during the next transfer.
- `reg_o`, out, REG_N*8: flattened register bank; reg k is at `[k*8+:8]`.
- `pix_o`, out, PIX_BYTES*8: last complete pixel word; the first received byte is in the MSB.
- `pix_vld_o`, out, 1: one-cycle strobe, high when `pix_o` updates.
- `stream_on_o`, out, 1: high while in the STREAM state.
- `screen_rst_o`, out, 1: screen/frame reset level for the pixel coordinator.
- `err_cnt_o`, out, 8: saturating count of unknown command bytes.

## Operation
States: CMD, RD_ADDR, WR_ADDR, WR_DATA, STREAM. Transitions occur only on `byte_rdy`, except for the deselect rule.

- **CMD.** `feed_o` ← 0xFF on every byte. Action by byte value:
  - 0x81: go to RD_ADDR.
  - 0x80: go to WR_ADDR.
  - 0x55: go to STREAM and clear the pixel byte counter.
  - 0x40: `screen_rst_o` ← 0; stay in CMD.
  - 0x41: `screen_rst_o` ← 1; stay in CMD.
  - Any other value: `err_cnt_o` increments, saturating at 255; stay in CMD.
- **RD_ADDR.** The byte is an address.
  - `feed_o` ← reg[addr] if addr < REG_N, otherwise 0x00.
  - Go to CMD.
- **WR_ADDR.** Latch the address; go to WR_DATA. `feed_o` ← 0xFF.
- **WR_DATA.** reg[addr] ← byte if addr < REG_N; an out-of-range write is discarded with no error count. Go to CMD. `feed_o` ← 0xFF.
- **STREAM.**
  - Each byte shifts into the pixel shift register.
  - `feed_o` ← `stream_dat_i`, sampled on the `byte_rdy` cycle.
  - The byte counter runs 0..PIX_BYTES-1. On the byte where the counter equals PIX_BYTES-1:
    - `pix_o` ← {shift[(PIX_BYTES-1)*8-1:0], byte_i};
    - `pix_vld_o` pulses;
    - the counter wraps to 0.
  - Command bytes are not decoded in STREAM. 0x55 and 0x80 are treated as pixel data.
- **Deselect.** `css`=0 in any cycle forces the following on the next edge:
  - state ← CMD;
  - byte counter ← 0;
  - partial pixel discarded;
  - `feed_o` ← 0xFF.

  Registers, `screen_rst_o`, `pix_o` and `err_cnt_o` keep their values.
- **Simultaneous events.** When `css`=0 and `byte_rdy`=1 in the same cycle, deselect wins and the byte is dropped with no side effects.
- **Reset.** `rst_p` asserted mid-operation aborts immediately to the reset state and loses any partial pixel.

## Timing
Reset values:
- state = CMD.
- `feed_o` = 0xFF.
- `reg_o` = 0.
- `pix_o` = 0.
- `pix_vld_o` = 0.
- `stream_on_o` = 0.
- `screen_rst_o` = 0.
- `err_cnt_o` = 0.

Latency:
- All effects of a byte are visible exactly one `clk_p` cycle after its `byte_rdy` cycle. This covers the register write, `feed_o`, `screen_rst_o`, the `stream_on_o` rise and `pix_vld_o`/`pix_o`.
- `stream_on_o` falls one cycle after the first `css`=0 cycle.

Rates and widths:
- `pix_vld_o` is never high for two consecutive cycles.
- Back-to-back `byte_rdy` on consecutive cycles must be accepted with no loss.
- `err_cnt_o` holds at 255 when saturated.

## Test plan
- **Reset.** Assert `rst_p` mid-stream after 3 pixel bytes. Required: all outputs at reset values; `feed_o`=0xFF. The next 0x55 then 6 bytes produce exactly one `pix_vld_o`.
- **Register write/read.** Send 0x80,0x02,0xA5, deselect, then 0x81,0x02,0x00. Required: `reg_o[23:16]`=0xA5 one cycle after the third byte; `feed_o`=0xA5 one cycle after the address byte 0x02. Repeat the read with address 0x09: `feed_o`=0x00.
- **Streaming.** Send 0x55 followed by 12 bytes 0x01..0x0C on consecutive `byte_rdy` cycles with `stream_dat_i`=0x3C. Required: two `pix_vld_o` pulses, with `pix_o`=0x010203040506 then 0x0708090A0B0C; `feed_o`=0x3C after each byte.
- **Deselect mid-pixel.** Send 0x55, 4 bytes, then `css`=0 coincident with a `byte_rdy`. Required: no `pix_vld_o`; state CMD; `stream_on_o`=0 next cycle; the next 0x55 plus 6 bytes yields one correct pixel.
- **Screen control and errors.** Send 0x41, then 0x40, then 300 bytes of 0x13. Required: `screen_rst_o` 1 then 0, each one cycle after its byte; `err_cnt_o` saturates at 255; registers unchanged.
